// File: rtl/enc_frame_ctrl_if.sv
// Beat-stream bundle between the frame controller and the cipher datapath.
//   in_valid  : reader beat strobe (reader hsync)
//   enc_ecb   : ECB core result for the current beat
//   enc_cbc   : CBC core result for the current beat
//   chain     : chaining vector to the CBC core IV input
//   out_valid : ciphertext beat strobe to the writer
//   out_data  : ciphertext beat
// master = controller side, slave = datapath / environment side.
interface enc_frame_ctrl_if #(
  parameter int unsigned DATA_W = 48
);
  logic              in_valid;
  logic [DATA_W-1:0] enc_ecb;
  logic [DATA_W-1:0] enc_cbc;
  logic [DATA_W-1:0] chain;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  in_valid, enc_ecb, enc_cbc,
    output chain, out_valid, out_data
  );

  modport slave (
    output in_valid, enc_ecb, enc_cbc,
    input  chain, out_valid, out_data
  );
endinterface

// File: rtl/enc_frame_ctrl.sv
// Frame-level sequencer for the image encryption datapath.
// Runs the key LFSR for KEY_CYCLES cycles, then loads the CBC chaining
// register from the IV, kicks the reader, counts beats per row/frame and
// registers the selected ciphertext toward the writer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : one-cycle frame request (honoured only in IDLE)
//   i_abort         : synchronous abort back to IDLE
//   i_mode          : 0 = ECB, 1 = CBC, latched on accepted start
//   i_iv            : current IV LFSR output
//   bus (master)    : beat stream in/out and chaining vector
//   o_key_en        : key LFSR enable (KEYGEN only)
//   o_core_en       : cipher core enable (RUN only)
//   o_frame_start   : one-cycle reader kick (ARM)
//   o_busy          : high outside IDLE
//   o_done          : one-cycle end-of-frame pulse
//   o_err           : sticky protocol error (beat outside RUN)
module enc_frame_ctrl #(
  parameter int unsigned HSIZE      = 768,
  parameter int unsigned VSIZE      = 512,
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned KEY_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_iv,
  enc_frame_ctrl_if.master  bus,
  output logic              o_key_en,
  output logic              o_core_en,
  output logic              o_frame_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned BEATS_PER_ROW = HSIZE / 2;
  localparam int unsigned COL_W  = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int unsigned ROW_W  = (VSIZE > 1) ? $clog2(VSIZE) : 1;
  localparam int unsigned KCNT_W = (KEY_CYCLES > 1) ? $clog2(KEY_CYCLES) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(VSIZE - 1);
  localparam logic [KCNT_W-1:0] KEY_LAST = KCNT_W'(KEY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYGEN,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_mode;
  logic [KCNT_W-1:0]   r_kcnt;
  logic [COL_W-1:0]    r_col_cnt;
  logic [ROW_W-1:0]    r_row_cnt;
  logic [DATA_W-1:0]   r_chain;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_key_en;
  logic                r_core_en;
  logic                r_frame_start;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic [DATA_W-1:0]   w_cipher;

  // A beat counts only while RUN and not being aborted.
  assign w_accept = (r_state == S_RUN) && bus.in_valid && !i_abort;
  assign w_cipher = r_mode ? bus.enc_cbc : bus.enc_ecb;

  // Sequencer: state, counters and every output are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_kcnt        <= '0;
      r_col_cnt     <= '0;
      r_row_cnt     <= '0;
      r_chain       <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_key_en      <= 1'b0;
      r_core_en     <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;

      // Sticky error on a reader beat arriving while not in RUN.
      if (bus.in_valid && (r_state != S_RUN)) begin
        r_err <= 1'b1;
      end

      // Output register: data holds between beats.
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cipher;
      end

      if (i_abort) begin
        // Chain and err deliberately untouched by abort.
        r_state   <= S_IDLE;
        r_kcnt    <= '0;
        r_col_cnt <= '0;
        r_row_cnt <= '0;
        r_key_en  <= 1'b0;
        r_core_en <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state  <= S_KEYGEN;
              r_mode   <= i_mode;
              r_kcnt   <= '0;
              r_key_en <= 1'b1;
              r_busy   <= 1'b1;
            end
          end

          S_KEYGEN: begin
            r_kcnt <= r_kcnt + KCNT_W'(1);
            if (r_kcnt == KEY_LAST) begin
              r_state       <= S_ARM;
              r_key_en      <= 1'b0;
              r_frame_start <= 1'b1;
            end
          end

          S_ARM: begin
            r_chain   <= i_iv;
            r_core_en <= 1'b1;
            r_state   <= S_RUN;
          end

          S_RUN: begin
            if (bus.in_valid) begin
              if (r_mode) begin
                r_chain <= bus.enc_cbc;
              end
              if (r_col_cnt == COL_LAST) begin
                r_col_cnt <= '0;
                if (r_row_cnt == ROW_LAST) begin
                  // Last beat of the frame: its output and done coincide.
                  r_state   <= S_DONE;
                  r_core_en <= 1'b0;
                  r_done    <= 1'b1;
                end else begin
                  r_row_cnt <= r_row_cnt + ROW_W'(1);
                end
              end else begin
                r_col_cnt <= r_col_cnt + COL_W'(1);
              end
            end
          end

          S_DONE: begin
            r_kcnt    <= '0;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end

          default: begin
            r_state   <= S_IDLE;
            r_key_en  <= 1'b0;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.chain     = r_chain;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_key_en      = r_key_en;
  assign o_core_en     = r_core_en;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_enc_frame_ctrl.sv
// Directed bench for enc_frame_ctrl with a 4x2-beat frame (HSIZE=8, VSIZE=2).
module tb_enc_frame_ctrl;

  localparam int unsigned DATA_W = 48;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              mode;
  logic [DATA_W-1:0] iv;
  logic              key_en;
  logic              core_en;
  logic              frame_start;
  logic              busy;
  logic              done;
  logic              err;

  int n_vec;
  int n_err;

  enc_frame_ctrl_if #(.DATA_W(DATA_W)) bus ();

  enc_frame_ctrl #(
    .HSIZE(8), .VSIZE(2), .DATA_W(DATA_W), .KEY_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_iv(iv), .bus(bus), .o_key_en(key_en), .o_core_en(core_en),
    .o_frame_start(frame_start), .o_busy(busy), .o_done(done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start request, 4 KEYGEN cycles, ARM with frame_start, then RUN with chain = iv.
  task automatic prologue(input logic m, input logic [DATA_W-1:0] v);
    mode  = m;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk1("keygen_busy", busy, 1'b1);
    chk1("key_en_c1", key_en, 1'b1);
    repeat (3) begin
      tick;
      chk1("key_en_hold", key_en, 1'b1);
      chk1("fs_keygen", frame_start, 1'b0);
    end
    iv = v;
    tick;
    chk1("key_en_off", key_en, 1'b0);
    chk1("frame_start", frame_start, 1'b1);
    chk1("core_en_arm", core_en, 1'b0);
    tick;
    chk1("fs_pulse_end", frame_start, 1'b0);
    chk1("core_en_run", core_en, 1'b1);
    chkd("chain_iv", bus.chain, v);
  endtask

  // Beats first..last of a frame; ECB/CBC results are base + k.
  task automatic beats(input int first, input int last, input logic [DATA_W-1:0] eb,
                       input logic [DATA_W-1:0] cb, input logic m);
    for (int k = first; k <= last; k++) begin
      bus.in_valid = 1'b1;
      bus.enc_ecb  = eb + DATA_W'(k);
      bus.enc_cbc  = cb + DATA_W'(k);
      tick;
      bus.in_valid = 1'b0;
      chk1("out_valid", bus.out_valid, 1'b1);
      chkd("out_data", bus.out_data, m ? cb + DATA_W'(k) : eb + DATA_W'(k));
      chk1("done", done, (k == 8));
    end
  endtask

  task automatic gap(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      tick;
      chk1("gap_out_valid", bus.out_valid, 1'b0);
    end
  endtask

  // Cycle after DONE: back in IDLE, output data held.
  task automatic finish_frame(input logic [DATA_W-1:0] last_data);
    tick;
    chk1("post_done", done, 1'b0);
    chk1("post_busy", busy, 1'b0);
    chk1("post_out_valid", bus.out_valid, 1'b0);
    chkd("out_data_hold", bus.out_data, last_data);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b1; abort = 1'b0; mode = 1'b0; iv = '0;
    bus.in_valid = 1'b0; bus.enc_ecb = '0; bus.enc_cbc = '0;

    // Reset with start held high
    tick; tick;
    chk1("rst_key_en", key_en, 1'b0);
    chk1("rst_core_en", core_en, 1'b0);
    chk1("rst_frame_start", frame_start, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chkd("rst_out_data", bus.out_data, '0);
    chkd("rst_chain", bus.chain, '0);
    rst = 1'b0; start = 1'b0;
    repeat (3) tick;
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_key_en", key_en, 1'b0);

    // ECB frame with a 3-cycle gap after beat 4
    prologue(1'b0, 48'h000000000123);
    beats(1, 4, 48'h0, 48'hDEAD00, 1'b0);
    gap(3);
    beats(5, 8, 48'h0, 48'hDEAD00, 1'b0);
    chkd("ecb_chain", bus.chain, 48'h000000000123);
    chk1("done_busy", busy, 1'b1);
    finish_frame(48'h8);

    // CBC frame; mode toggled after acceptance must not matter
    prologue(1'b1, 48'hA5A5A5A5A5A5);
    mode = 1'b0;
    beats(1, 1, 48'hBAD000, 48'h10, 1'b1);
    chkd("cbc_chain_b1", bus.chain, 48'h11);
    beats(2, 8, 48'hBAD000, 48'h10, 1'b1);
    chkd("cbc_chain_b8", bus.chain, 48'h18);
    finish_frame(48'h18);

    // Abort after beat 5
    prologue(1'b0, 48'h77);
    beats(1, 5, 48'h20, 48'hDEAD00, 1'b0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_out_valid", bus.out_valid, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_core_en", core_en, 1'b0);
    chkd("abort_chain", bus.chain, 48'h77);
    tick;
    chk1("abort_no_done", done, 1'b0);

    // Abort and start together in IDLE
    abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    chk1("abort_start_busy", busy, 1'b0);
    chk1("abort_start_key_en", key_en, 1'b0);
    tick;
    chk1("abort_start_idle", busy, 1'b0);

    // Full frame after abort: counters restarted
    prologue(1'b0, 48'h78);
    beats(1, 8, 48'h30, 48'hDEAD00, 1'b0);
    finish_frame(48'h38);

    // Protocol error in IDLE, then start ignored during RUN
    chk1("err_clear", err, 1'b0);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk1("err_set", err, 1'b1);
    chk1("err_no_out", bus.out_valid, 1'b0);
    prologue(1'b0, 48'h99);
    beats(1, 2, 48'h40, 48'hDEAD00, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk1("run_start_busy", busy, 1'b1);
    chk1("run_start_key_en", key_en, 1'b0);
    chk1("run_start_core_en", core_en, 1'b1);
    beats(3, 8, 48'h40, 48'hDEAD00, 1'b0);
    chk1("err_sticky", err, 1'b1);
    finish_frame(48'h48);

    // Back-to-back: start in the cycle right after DONE
    prologue(1'b1, 48'h5A5A);
    beats(1, 8, 48'hBAD000, 48'h50, 1'b1);
    finish_frame(48'h58);
    chk1("err_final", err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
